// File: rtl/rgb_mixer_n.sv
// rgb_mixer_n: N-channel quadrature encoder to PWM LED mixer.
// Debounced encoders drive per-channel levels; PWM shares one counter.
module rgb_mixer_n #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int HIST_LEN = 8,
    parameter int STEP     = 1,
    parameter int SATURATE = 1,
    parameter int STAGGER  = 1,
    localparam int LCW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enc_a,
    input  logic [CHANNELS-1:0]       enc_b,
    input  logic                      load_en,
    input  logic [LCW-1:0]            load_ch,
    input  logic [WIDTH-1:0]          load_value,
    output logic [CHANNELS*WIDTH-1:0] value,
    output logic [CHANNELS-1:0]       pwm_out
);

    localparam int NIN = 2 * CHANNELS;
    localparam int OFF = (STAGGER != 0) ? (2 ** WIDTH) / CHANNELS : 0;
    localparam logic [WIDTH-1:0] MAXV   = '1;
    localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);

    logic [NIN-1:0]      raw;
    logic [HIST_LEN-1:0] hist [NIN];
    logic [NIN-1:0]      deb;
    logic [CHANNELS-1:0] deb_a;
    logic [CHANNELS-1:0] deb_b;
    logic [CHANNELS-1:0] prev_a;
    logic [CHANNELS-1:0] load_hit;
    logic [WIDTH-1:0]    lvl    [CHANNELS];
    logic [WIDTH-1:0]    nxt    [CHANNELS];
    logic [WIDTH:0]      up_sum [CHANNELS];
    logic [WIDTH:0]      dn_sum [CHANNELS];
    logic [WIDTH-1:0]    shadow [CHANNELS];
    logic [WIDTH-1:0]    phase  [CHANNELS];
    logic [WIDTH-1:0]    cnt;

    assign raw   = {enc_b, enc_a};
    assign deb_a = deb[CHANNELS-1:0];
    assign deb_b = deb[NIN-1:CHANNELS];

    // Debounce: output follows input only after HIST_LEN equal samples
    always_ff @(posedge clk) begin
        if (!reset) begin
            deb <= '0;
            for (int j = 0; j < NIN; j++) begin
                hist[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NIN; j++) begin
                hist[j] <= {hist[j][HIST_LEN-2:0], raw[j]};
                if (&hist[j]) begin
                    deb[j] <= 1'b1;
                end else if (~|hist[j]) begin
                    deb[j] <= 1'b0;
                end
            end
        end
    end

    // Next level: preload wins over a same-channel encoder event
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            load_hit[i] = load_en && (32'(load_ch) == i);
            up_sum[i]   = {1'b0, lvl[i]} + STEP_X;
            dn_sum[i]   = {1'b0, lvl[i]} - STEP_X;
            nxt[i]      = lvl[i];
            if (load_hit[i]) begin
                nxt[i] = load_value;
            end else if (deb_a[i] != prev_a[i]) begin
                if (deb_a[i] != deb_b[i]) begin
                    nxt[i] = (SATURATE != 0 && up_sum[i][WIDTH]) ?
                             MAXV : up_sum[i][WIDTH-1:0];
                end else begin
                    nxt[i] = (SATURATE != 0 && dn_sum[i][WIDTH]) ?
                             '0 : dn_sum[i][WIDTH-1:0];
                end
            end
        end
    end

    // Level registers and previous-A copies for edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_a <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                lvl[i] <= '0;
            end
        end else begin
            prev_a <= deb_a;
            for (int i = 0; i < CHANNELS; i++) begin
                lvl[i] <= nxt[i];
            end
        end
    end

    // Per-channel phase derived from the shared counter
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            phase[i] = cnt + WIDTH'(i * OFF);
        end
    end

    // Shared counter, shadow latch at period end, registered compare
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            pwm_out <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            cnt <= cnt + WIDTH'(1);
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= (phase[i] < shadow[i]);
                if (phase[i] == MAXV) begin
                    shadow[i] <= lvl[i];
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_value
        assign value[g*WIDTH +: WIDTH] = lvl[g];
    end

endmodule

// File: tb/tb_rgb_mixer_n.sv
// tb_rgb_mixer_n: random and directed stimulus against a behavioural model.
// Two instances: saturating STEP=16 and wrapping STEP=1.
module tb_rgb_mixer_n;

    localparam int CH  = 3;
    localparam int W   = 8;
    localparam int H   = 8;
    localparam int OFF = 85;
    localparam int LCW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] enc_a;
    logic [CH-1:0] enc_b;
    logic          load_en;
    logic [LCW-1:0] load_ch;
    logic [W-1:0]  load_value;
    logic [CH*W-1:0] val_s;
    logic [CH*W-1:0] val_w;
    logic [CH-1:0] pwm_s;
    logic [CH-1:0] pwm_w;

    always #5 clk = ~clk;

    rgb_mixer_n #(
        .CHANNELS(CH), .WIDTH(W), .HIST_LEN(H),
        .STEP(16), .SATURATE(1), .STAGGER(1)
    ) u_sat (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .load_en(load_en), .load_ch(load_ch), .load_value(load_value),
        .value(val_s), .pwm_out(pwm_s)
    );

    rgb_mixer_n #(
        .CHANNELS(CH), .WIDTH(W), .HIST_LEN(H),
        .STEP(1), .SATURATE(0), .STAGGER(1)
    ) u_wrap (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .load_en(load_en), .load_ch(load_ch), .load_value(load_value),
        .value(val_w), .pwm_out(pwm_w)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: debounce as run-length of identical samples
    int m_run  [2*CH];
    bit m_last [2*CH];
    bit m_deb  [2*CH];
    bit m_prev [CH];
    int m_cnt;
    int m_val  [2][CH];
    int m_sh   [2][CH];
    bit m_pwm  [2][CH];
    int stp [2] = '{16, 1};
    bit sat [2] = '{1'b1, 1'b0};

    function automatic int step_val(int v, bit up, int s, bit sa);
        int r;
        if (up) begin
            r = v + s;
            if (r > 255) r = sa ? 255 : r - 256;
        end else begin
            r = v - s;
            if (r < 0) r = sa ? 0 : r + 256;
        end
        return r;
    endfunction

    task automatic model_step();
        bit ev [CH];
        bit up [CH];
        bit rb;
        int p;
        if (!reset) begin
            for (int j = 0; j < 2*CH; j++) begin
                m_run[j] = H; m_last[j] = 0; m_deb[j] = 0;
            end
            m_cnt = 0;
            for (int c = 0; c < CH; c++) begin
                m_prev[c] = 0;
                for (int k = 0; k < 2; k++) begin
                    m_val[k][c] = 0; m_sh[k][c] = 0; m_pwm[k][c] = 0;
                end
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                ev[c] = (m_deb[c] != m_prev[c]);
                up[c] = (m_deb[c] != m_deb[CH+c]);
            end
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < CH; c++) begin
                    p = (m_cnt + c*OFF) % 256;
                    m_pwm[k][c] = (p < m_sh[k][c]);
                    if (p == 255) m_sh[k][c] = m_val[k][c];
                    if (load_en && int'(load_ch) == c)
                        m_val[k][c] = int'(load_value);
                    else if (ev[c])
                        m_val[k][c] = step_val(m_val[k][c], up[c],
                                               stp[k], sat[k]);
                end
            end
            for (int c = 0; c < CH; c++) m_prev[c] = m_deb[c];
            for (int j = 0; j < 2*CH; j++) begin
                if (m_run[j] >= H) m_deb[j] = m_last[j];
                rb = (j < CH) ? enc_a[j] : enc_b[j-CH];
                if (rb == m_last[j]) begin
                    if (m_run[j] < H) m_run[j]++;
                end else begin
                    m_last[j] = rb;
                    m_run[j]  = 1;
                end
            end
            m_cnt = (m_cnt + 1) % 256;
        end
    endtask

    function automatic logic [CH*W-1:0] packv(int k);
        logic [CH*W-1:0] r;
        for (int c = 0; c < CH; c++) r[c*W +: W] = W'(m_val[k][c]);
        return r;
    endfunction

    function automatic logic [CH-1:0] packp(int k);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = m_pwm[k][c];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("val_sat",  val_s, packv(0));
        check("val_wrap", val_w, packv(1));
        check("pwm_sat",  pwm_s, packp(0));
        check("pwm_wrap", pwm_w, packp(1));
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic load(input int ch, input int v);
        load_en = 1'b1; load_ch = LCW'(ch); load_value = W'(v);
        tick();
        load_en = 1'b0;
    endtask

    task automatic enc_event(input int ch, input bit up);
        enc_b[ch] = up ? enc_a[ch] : ~enc_a[ch];
        ticks(H + 2);
        enc_a[ch] = ~enc_a[ch];
        ticks(H + 2);
    endtask

    initial begin
        logic [CH*W-1:0] snap_s, snap_w;
        int hi [CH];
        int rise [CH];
        logic [CH-1:0] prv;
        int hi0;
        bit found;

        reset = 1'b0; load_en = 1'b0; load_ch = '0; load_value = '0;
        enc_a = '0; enc_b = '0;

        repeat (3) begin
            enc_a = CH'($urandom); enc_b = CH'($urandom);
            tick();
            check("rst_val_s", val_s, 0);
            check("rst_val_w", val_w, 0);
            check("rst_pwm", {pwm_s, pwm_w}, 0);
        end
        reset = 1'b1; enc_a = '0; enc_b = '0;
        ticks(4);

        enc_a[0] = 1'b1;
        ticks(7);
        enc_a[0] = 1'b0;
        ticks(12);
        check("bounce_w", val_w[7:0], 0);
        check("bounce_s", val_s[7:0], 0);

        enc_a[0] = 1'b1;
        ticks(9);
        check("lat_pre", val_w[7:0], 0);
        tick();
        check("lat_w", val_w[7:0], 1);
        check("lat_s", val_s[7:0], 16);
        ticks(4);

        load(1, 250);
        enc_event(1, 1'b1);
        check("sat_up", val_s[W*1 +: W], 255);
        repeat (3) begin
            enc_event(1, 1'b1);
            check("sat_hold", val_s[W*1 +: W], 255);
        end
        load(1, 5);
        enc_event(1, 1'b0);
        check("sat_dn", val_s[W*1 +: W], 0);

        load(2, 255);
        enc_event(2, 1'b1);
        check("wrap_up", val_w[W*2 +: W], 0);
        enc_event(2, 1'b0);
        check("wrap_dn", val_w[W*2 +: W], 255);

        load(1, 3);
        enc_b[0] = enc_a[0];
        enc_b[1] = enc_a[1];
        ticks(H + 2);
        enc_a[0] = ~enc_a[0];
        enc_a[1] = ~enc_a[1];
        ticks(H + 1);
        load_en = 1'b1; load_ch = 2'd0; load_value = 8'h40;
        tick();
        load_en = 1'b0;
        check("prio_ch0", val_w[W*0 +: W], 8'h40);
        check("prio_ch1", val_w[W*1 +: W], 4);
        check("prio_ch1s", val_s[W*1 +: W], 19);
        ticks(2);
        snap_s = val_s; snap_w = val_w;
        load_en = 1'b1; load_ch = 2'd3; load_value = 8'h99;
        tick();
        load_en = 1'b0;
        ticks(2);
        check("bad_ch_w", val_w, snap_w);
        check("bad_ch_s", val_s, snap_s);

        load(0, 64); load(1, 64); load(2, 64);
        ticks(300);
        prv = pwm_w;
        for (int c = 0; c < CH; c++) begin
            hi[c] = 0; rise[c] = -1;
        end
        for (int k = 0; k < 256; k++) begin
            tick();
            for (int c = 0; c < CH; c++) begin
                if (pwm_w[c]) hi[c]++;
                if (pwm_w[c] && !prv[c]) rise[c] = k;
            end
            prv = pwm_w;
        end
        for (int c = 0; c < CH; c++) check("duty64", hi[c], 64);
        check("stag01", (rise[0] - rise[1] + 256) % 256, 85);
        check("stag12", (rise[1] - rise[2] + 256) % 256, 85);

        found = 1'b0;
        prv = pwm_w;
        for (int k = 0; k < 300 && !found; k++) begin
            tick();
            if (pwm_w[0] && !prv[0]) found = 1'b1;
            prv = pwm_w;
        end
        check("rise_seen", found, 1);
        hi0 = 1;
        for (int k = 1; k < 256; k++) begin
            if (k == 10) begin
                load_en = 1'b1; load_ch = 2'd0; load_value = 8'd128;
            end
            tick();
            load_en = 1'b0;
            if (pwm_w[0]) hi0++;
        end
        check("mid_old", hi0, 64);
        hi0 = 0;
        for (int k = 0; k < 256; k++) begin
            tick();
            if (pwm_w[0]) hi0++;
        end
        check("mid_new", hi0, 128);

        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 9) == 0) enc_a[c] = ~enc_a[c];
                if ($urandom_range(0, 9) == 0) enc_b[c] = ~enc_b[c];
            end
            load_en    = ($urandom_range(0, 15) == 0);
            load_ch    = LCW'($urandom_range(0, 3));
            load_value = W'($urandom);
            reset      = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rgb_mixer_n.md
Name: rgb_mixer_n

Overview:
- Parametrised N-channel successor to the three-channel encoder/PWM mixer.
- Each channel has:
  - two debouncers on its quadrature inputs;
  - a quadrature decoder driving a WIDTH-bit level register, with a selectable step and saturate/wrap mode;
  - a host preload port;
  - a glitch-free PWM output whose level is shadow-latched at period boundaries.
- The PWM counter is shared; per-channel phase staggering reduces simultaneous switching. Sits at the top of the LED driver, between the pad inputs and the LED drive pins.

Parameters:
- CHANNELS, 3, number of encoder/PWM channels (1..16).
- WIDTH, 8, level and PWM counter width in bits (2..16).
- HIST_LEN, 8, debounce history length in samples (2..32).
- STEP, 1, amount added or subtracted per decoded encoder event (1..2^WIDTH-1).
- SATURATE, 1. 1 = clamp at 0 and 2^WIDTH-1. 0 = modulo-2^WIDTH wrap.
- STAGGER, 1. 1 = channel i PWM phase offset by i*floor(2^WIDTH/CHANNELS). 0 = all channels in phase.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- enc_a  input  CHANNELS  raw encoder A inputs; bit i belongs to channel i.
- enc_b  input  CHANNELS  raw encoder B inputs; bit i belongs to channel i.
- load_en  input  1  host preload strobe, single cycle.
- load_ch  input  max(1,$clog2(CHANNELS))  channel index for the preload.
- load_value  input  WIDTH  value to preload.
- value  output  CHANNELS*WIDTH  current level registers; channel i at [i*WIDTH +: WIDTH].
- pwm_out  output  CHANNELS  registered PWM outputs; bit i belongs to channel i.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low.
  - reset low at a rising edge clears every register: debounce histories, debounced outputs, previous-A flags, value, shadow levels, PWM counter and pwm_out all go to 0.
  - Reset asserted mid-operation takes effect on that edge, with no partial updates.
- Debounce (per input):
  - Shift register of HIST_LEN samples; the raw input is shifted in every cycle.
  - Debounced output is a register. It sets to 1 when the history is all ones, clears to 0 when all zeros, otherwise holds.
  - A raw input stable from edge t changes the debounced output at edge t+HIST_LEN.
  - Pulses shorter than HIST_LEN cycles never propagate.
- Decode (per channel):
  - An event occurs on any change of debounced A versus its previous-cycle copy.
  - Direction is up if new A != debounced B, down otherwise. This gives two events per full quadrature cycle.
  - An event updates value on the edge following the debounced-A change. Total raw-to-value latency is HIST_LEN+1 cycles.
- Arithmetic, computed at WIDTH+1 bits:
  - SATURATE=1: up gives min(v+STEP, 2^WIDTH-1); down gives max(v-STEP, 0). At the bounds, further events in the same direction leave value unchanged.
  - SATURATE=0: result is (v±STEP) mod 2^WIDTH.
- Preload:
  - load_en=1 with load_ch<CHANNELS writes load_value into that channel's value on the next edge.
  - A simultaneous encoder event on the same channel is discarded; the load wins.
  - Other channels' events proceed normally.
  - load_ch>=CHANNELS: the load is ignored.
- PWM:
  - Shared WIDTH-bit counter cnt increments every cycle and wraps from 2^WIDTH-1 to 0.
  - Channel phase p_i = (cnt + i*OFF) mod 2^WIDTH, where OFF is defined by STAGGER.
  - shadow_i loads value_i on the edge where p_i == 2^WIDTH-1, so a new level takes effect from p_i==0. There are no mid-period changes.
  - pwm_out_i is registered as (p_i < shadow_i), one cycle after the phase.
  - Level 0 gives a constant low output. Level L gives exactly L high cycles per 2^WIDTH-cycle period; level 2^WIDTH-1 gives one low cycle per period.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with random inputs -> value=0 and pwm_out=0 throughout; cnt=0 on release.
2. Bounce rejection (WIDTH=8, HIST_LEN=8): enc0_a pulses high for 7 cycles -> value0 stays 0. Hold it high, with B low, for ≥8 cycles -> value0=1 exactly 9 cycles after the stable start.
3. Saturation (SATURATE=1, STEP=16): preload ch1=250, then one up event -> 255; 3 further ups -> 255. Preload 5, one down event -> 0.
4. Wrap (SATURATE=0, STEP=1): preload ch2=255, up event -> 0; down event -> 255.
5. Preload priority: load_en with load_ch=0, load_value=0x40, in the same cycle as an up event on ch0 and on ch1 (ch1 starting at 3) -> ch0=0x40, ch1=4. load_ch=3 with CHANNELS=3 -> no change.
6. PWM and stagger (WIDTH=8, CHANNELS=3, STAGGER=1):
   - All levels 64 -> each output high 64 of 256 cycles, with rising edges 85 cycles apart.
   - Changing value mid-period -> the duty cycle changes only from the next period of that channel.
